// File: rtl/delta_event_scheduler_pkg.sv
// Shared types and helpers for the delta event scheduler.
package delta_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        CLEAR   = 2'd2,
        SETTLE  = 2'd3
    } sched_state_e;

    function automatic int id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/delta_event_scheduler_rr_picker.sv
// Combinational round-robin search: first set request at or above PTR, wrapping.
module rr_picker
    import delta_sched_pkg::*;
#(
    parameter  int NUM_SOURCES = 8,
    localparam int ID_W        = id_width(NUM_SOURCES)
) (
    input  logic [NUM_SOURCES-1:0] REQ,
    input  logic [ID_W-1:0]        PTR,
    output logic [ID_W-1:0]        GRANT_ID,
    output logic                   GRANT_VALID
);

    int              sum_s;
    logic [ID_W-1:0] idx_s;

    // Walk the requests starting at PTR and keep the first hit
    always_comb begin
        GRANT_ID    = '0;
        GRANT_VALID = 1'b0;
        sum_s       = 0;
        idx_s       = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            sum_s = int'(PTR) + i;
            idx_s = (sum_s >= NUM_SOURCES) ? ID_W'(sum_s - NUM_SOURCES) : ID_W'(sum_s);
            if (REQ[idx_s] && !GRANT_VALID) begin
                GRANT_VALID = 1'b1;
                GRANT_ID    = idx_s;
            end else begin
                GRANT_VALID = GRANT_VALID;
            end
        end
    end

endmodule

// File: rtl/delta_event_scheduler.sv
// Round-robin delivery of delta-register change events over valid/ready.
// Optional handshake watchdog: define DELTA_SCHED_TIMEOUT_EN.
module delta_event_scheduler
    import delta_sched_pkg::*;
#(
    parameter  int NUM_SOURCES    = 8,
    parameter  int DATA_WIDTH     = 32,
    parameter  int TIMEOUT_CYCLES = 1024,
    localparam int ID_W           = id_width(NUM_SOURCES)
) (
    input  logic                              CLK,
    input  logic                              RSTN,
    input  logic [NUM_SOURCES-1:0]            CHANGE_IN,
    input  logic [NUM_SOURCES*DATA_WIDTH-1:0] VALUE_IN,
    input  logic [NUM_SOURCES-1:0]            ENABLE_MASK,
    output logic [NUM_SOURCES-1:0]            READ_EVENT_OUT,
    output logic                              EVT_VALID,
    input  logic                              EVT_READY,
    output logic [ID_W-1:0]                   EVT_ID,
    output logic [DATA_WIDTH-1:0]             EVT_VALUE,
    output logic                              IRQ
`ifdef DELTA_SCHED_TIMEOUT_EN
   ,output logic                              TIMEOUT_FLAG
`endif
);

    sched_state_e            state_r;
    logic [ID_W-1:0]         rr_ptr_r;
    logic                    evt_valid_r;
    logic [ID_W-1:0]         evt_id_r;
    logic [DATA_WIDTH-1:0]   evt_value_r;
    logic [NUM_SOURCES-1:0]  read_event_r;
    logic                    irq_r;

    logic [NUM_SOURCES-1:0]  pending_s;
    logic [ID_W-1:0]         pick_id_s;
    logic                    pick_valid_s;
    logic [DATA_WIDTH-1:0]   pick_value_s;
    logic [NUM_SOURCES-1:0]  onehot_s;
    logic [ID_W-1:0]         next_ptr_s;
    logic                    handshake_s;
    logic                    tmo_hit_s;

    assign pending_s   = CHANGE_IN & ENABLE_MASK;
    assign handshake_s = evt_valid_r & EVT_READY;
    assign next_ptr_s  = (evt_id_r == ID_W'(NUM_SOURCES - 1)) ? '0 : evt_id_r + ID_W'(1);

    rr_picker #(
        .NUM_SOURCES (NUM_SOURCES)
    ) u_picker (
        .REQ         (pending_s),
        .PTR         (rr_ptr_r),
        .GRANT_ID    (pick_id_s),
        .GRANT_VALID (pick_valid_s)
    );

    // Value snapshot mux and clear-pulse decode of the held event id
    always_comb begin
        pick_value_s = '0;
        onehot_s     = '0;
        for (int i = 0; i < NUM_SOURCES; i++) begin
            if (pick_id_s == ID_W'(i)) begin
                pick_value_s = VALUE_IN[i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                pick_value_s = pick_value_s;
            end
            onehot_s[i] = (evt_id_r == ID_W'(i));
        end
    end

`ifdef DELTA_SCHED_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_cnt_r;
    logic             timeout_flag_r;

    assign tmo_hit_s    = (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES));
    assign TIMEOUT_FLAG = timeout_flag_r;

    // Watchdog counts PRESENT cycles; the flag sticks until reset
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            tmo_cnt_r      <= '0;
            timeout_flag_r <= 1'b0;
        end else if (state_r == IDLE) begin
            tmo_cnt_r <= '0;
        end else if ((state_r == PRESENT) && !handshake_s) begin
            tmo_cnt_r      <= tmo_hit_s ? tmo_cnt_r : tmo_cnt_r + TMO_W'(1);
            timeout_flag_r <= timeout_flag_r | tmo_hit_s;
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end
`else
    logic tmo_cfg_unused_s;

    assign tmo_hit_s        = 1'b0;
    assign tmo_cfg_unused_s = (TIMEOUT_CYCLES > 0);
`endif

    // Event sequencing: grant, present, clear pulse, settle
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_r      <= IDLE;
            rr_ptr_r     <= '0;
            evt_valid_r  <= 1'b0;
            evt_id_r     <= '0;
            evt_value_r  <= '0;
            read_event_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    read_event_r <= '0;
                    if (pick_valid_s) begin
                        evt_id_r    <= pick_id_s;
                        evt_value_r <= pick_value_s;
                        evt_valid_r <= 1'b1;
                        state_r     <= PRESENT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                PRESENT: begin
                    if (handshake_s || tmo_hit_s) begin
                        rr_ptr_r     <= next_ptr_s;
                        evt_valid_r  <= 1'b0;
                        read_event_r <= onehot_s;
                        state_r      <= CLEAR;
                    end else begin
                        state_r <= PRESENT;
                    end
                end
                CLEAR: begin
                    read_event_r <= '0;
                    state_r      <= SETTLE;
                end
                SETTLE: begin
                    read_event_r <= '0;
                    state_r      <= IDLE;
                end
                default: begin
                    evt_valid_r  <= 1'b0;
                    read_event_r <= '0;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

    // Interrupt tracks enabled pending flags regardless of FSM state
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= |pending_s;
        end
    end

    assign READ_EVENT_OUT = read_event_r;
    assign EVT_VALID      = evt_valid_r;
    assign EVT_ID         = evt_id_r;
    assign EVT_VALUE      = evt_value_r;
    assign IRQ            = irq_r;

endmodule

// File: tb/tb_delta_event_scheduler.sv
// Directed and randomized checks of delta_event_scheduler against a transaction-level model.
module tb_delta_event_scheduler;

    localparam int N   = 8;
    localparam int DW  = 32;
    localparam int TMO = 16;
    localparam int IDW = 3;

    logic            CLK = 1'b0;
    logic            RSTN;
    logic [N-1:0]    chg;
    logic [N*DW-1:0] val;
    logic [N-1:0]    mask;
    logic            ready;
    logic [N-1:0]    READ_EVENT_OUT;
    logic            EVT_VALID;
    logic [IDW-1:0]  EVT_ID;
    logic [DW-1:0]   EVT_VALUE;
    logic            IRQ;
`ifdef DELTA_SCHED_TIMEOUT_EN
    logic            TIMEOUT_FLAG;
`endif

    delta_event_scheduler #(
        .NUM_SOURCES    (N),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLK            (CLK),
        .RSTN           (RSTN),
        .CHANGE_IN      (chg),
        .VALUE_IN       (val),
        .ENABLE_MASK    (mask),
        .READ_EVENT_OUT (READ_EVENT_OUT),
        .EVT_VALID      (EVT_VALID),
        .EVT_READY      (ready),
        .EVT_ID         (EVT_ID),
        .EVT_VALUE      (EVT_VALUE),
        .IRQ            (IRQ)
`ifdef DELTA_SCHED_TIMEOUT_EN
       ,.TIMEOUT_FLAG   (TIMEOUT_FLAG)
`endif
    );

    always #5 CLK = ~CLK;

    int vectors     = 0;
    int miscompares = 0;

    // Transaction-level reference: current offered event, pointer, and earliest re-arbitration cycle
    bit           m_valid;
    int           m_id;
    logic [DW-1:0] m_value;
    int           m_ptr;
    logic [N-1:0] m_read;
    bit           m_irq;
    int           m_allow;
    int           m_cnt;
    bit           m_tflag;
    int           cyc;
    logic [N-1:0] clear_pend;
    bit           auto_clear;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_valid    = 1'b0;
        m_id       = 0;
        m_value    = '0;
        m_ptr      = 0;
        m_read     = '0;
        m_irq      = 1'b0;
        m_allow    = 0;
        m_cnt      = 0;
        m_tflag    = 1'b0;
        clear_pend = '0;
    endtask

    task automatic model_step();
        logic [N-1:0] pend;
        logic [N-1:0] rd;
        bit fin;
        bit tmo;
        pend = chg & mask;
        rd   = '0;
        fin  = 1'b0;
        tmo  = 1'b0;
        if (m_valid) begin
            if (ready) fin = 1'b1;
`ifdef DELTA_SCHED_TIMEOUT_EN
            else if (m_cnt == TMO) begin
                fin = 1'b1;
                tmo = 1'b1;
            end else m_cnt++;
`endif
        end
        if (fin) begin
            rd[m_id] = 1'b1;
            m_ptr    = (m_id + 1) % N;
            m_valid  = 1'b0;
            m_allow  = cyc + 3;
            if (tmo) m_tflag = 1'b1;
        end else if (!m_valid && cyc >= m_allow && pend != '0) begin
            for (int k = 0; k < N; k++) begin
                if (pend[(m_ptr + k) % N]) begin
                    m_id = (m_ptr + k) % N;
                    break;
                end
            end
            m_value = val[m_id*DW +: DW];
            m_valid = 1'b1;
            m_cnt   = 0;
        end
        clear_pend = m_read;
        m_read     = rd;
        m_irq      = |pend;
        cyc++;
    endtask

    task automatic compare_outputs();
        check("evt_valid", EVT_VALID, m_valid);
        check("read_event", READ_EVENT_OUT, m_read);
        check("irq", IRQ, m_irq);
        if (m_valid) begin
            check("evt_id", EVT_ID, m_id);
            check("evt_value", EVT_VALUE, m_value);
        end
`ifdef DELTA_SCHED_TIMEOUT_EN
        check("timeout_flag", TIMEOUT_FLAG, m_tflag);
`endif
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
        compare_outputs();
        @(negedge CLK);
        if (auto_clear) chg = chg & ~clear_pend;
    endtask

    task automatic apply_reset(input int hold);
        RSTN = 1'b0;
        #1;
        check("rst_valid", EVT_VALID, 1'b0);
        check("rst_id", EVT_ID, 0);
        check("rst_value", EVT_VALUE, 0);
        check("rst_read_event", READ_EVENT_OUT, 0);
        check("rst_irq", IRQ, 1'b0);
        model_reset();
        repeat (hold) @(negedge CLK);
        RSTN = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int last;
        int ones;
        bit prev_v;

        RSTN = 1'b0;
        chg = '0;
        val = '0;
        mask = '1;
        ready = 1'b0;
        auto_clear = 1'b1;
        cyc = 0;
        model_reset();
        repeat (2) @(negedge CLK);
        apply_reset(1);

        // Single source with explicit spec-derived values
        val[2*DW +: DW] = 32'hDEADBEEF;
        chg = 8'h04;
        ready = 1'b1;
        tick();
        check("single_valid", EVT_VALID, 1'b1);
        check("single_id", EVT_ID, 2);
        check("single_value", EVT_VALUE, 32'hDEADBEEF);
        tick();
        check("single_clear", READ_EVENT_OUT, 8'h04);
        tick();
        check("single_clear_off", READ_EVENT_OUT, 8'h00);
        repeat (3) tick();

        // Fairness with all flags held high
        apply_reset(1);
        auto_clear = 1'b0;
        chg = 8'hFF;
        ready = 1'b1;
        seen = 0;
        last = 0;
        prev_v = 1'b0;
        for (int c = 0; c < 60 && seen < 9; c++) begin
            tick();
            if (EVT_VALID && !prev_v) begin
                check("fair_id", EVT_ID, seen % N);
                if (seen > 0) check("fair_spacing", cyc - last, 4);
                last = cyc;
                seen++;
            end
            prev_v = EVT_VALID;
        end
        check("fair_count", seen, 9);
        chg = '0;
        auto_clear = 1'b1;
        repeat (4) tick();

        // Backpressure: value snapshot held while inputs churn
        apply_reset(1);
        val[4*DW +: DW] = 32'h12345678;
        chg = 8'h10;
        ready = 1'b0;
        tick();
        for (int c = 0; c < 20; c++) begin
            for (int k = 0; k < N; k++) val[k*DW +: DW] = $urandom;
            tick();
            check("bp_value", EVT_VALUE, 32'h12345678);
            check("bp_no_clear", READ_EVENT_OUT, 8'h00);
        end
        ready = 1'b1;
        repeat (4) tick();

        // Mask excludes source 0
        apply_reset(1);
        mask = 8'hFE;
        chg = 8'h03;
        ready = 1'b1;
        ones = 0;
        prev_v = 1'b0;
        tick();
        check("mask_irq", IRQ, 1'b1);
        for (int c = 0; c < 16; c++) begin
            if (EVT_VALID && !prev_v) begin
                check("mask_id", EVT_ID, 1);
                ones++;
            end
            prev_v = EVT_VALID;
            check("mask_no_clear0", READ_EVENT_OUT[0], 1'b0);
            tick();
        end
        check("mask_deliveries", ones, 1);
        mask = '1;
        repeat (8) tick();

        // Reset in the middle of PRESENT, then re-delivery
        apply_reset(1);
        chg = 8'h20;
        ready = 1'b0;
        tick();
        tick();
        check("midrst_valid", EVT_VALID, 1'b1);
        check("midrst_id", EVT_ID, 5);
        apply_reset(2);
        tick();
        check("midrst_redeliver_valid", EVT_VALID, 1'b1);
        check("midrst_redeliver_id", EVT_ID, 5);
        ready = 1'b1;
        repeat (5) tick();

`ifdef DELTA_SCHED_TIMEOUT_EN
        // Watchdog drops a stalled event and latches the flag
        apply_reset(1);
        chg = 8'h08;
        ready = 1'b0;
        repeat (25) tick();
        check("tmo_flag_set", TIMEOUT_FLAG, 1'b1);
        ready = 1'b1;
        repeat (5) tick();
        check("tmo_flag_sticky", TIMEOUT_FLAG, 1'b1);
`endif

        // Randomized traffic
        apply_reset(1);
        for (int c = 0; c < 800; c++) begin
            for (int k = 0; k < N; k++) val[k*DW +: DW] = $urandom;
            if ($urandom_range(0, 3) == 0) chg = chg | N'($urandom);
            if ($urandom_range(0, 31) == 0) mask = N'($urandom);
            ready = ($urandom_range(0, 2) != 0);
            if (c == 400) apply_reset(1);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/delta_event_scheduler.md
# delta_event_scheduler

Round-robin scheduler that collects the change flags of up to NUM_SOURCES delta registers and delivers one pending change at a time to a host over a valid/ready handshake. Each delivered event carries the source index and a snapshot of that source's value. After the host accepts an event, the block pulses the matching per-source read-event line to clear the flag. It sits between the bank of delta registers and the host-side interrupt/readout logic, so no single noisy source can starve the others.

## Interface
Parameters:
- NUM_SOURCES, 8: number of delta registers served (≥1).
- DATA_WIDTH, 32: width of each source value.
- TIMEOUT_CYCLES, 1024: handshake watchdog limit. Used only when DELTA_SCHED_TIMEOUT_EN is defined.

Ports:
- CLK  in  1  single clock, rising edge.
- RSTN  in  1  asynchronous, active-low reset.
- CHANGE_IN  in  NUM_SOURCES  per-source change flags from the delta registers.
- VALUE_IN  in  NUM_SOURCES*DATA_WIDTH  flattened source values; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- ENABLE_MASK  in  NUM_SOURCES  1 = source participates in arbitration.
- READ_EVENT_OUT  out  NUM_SOURCES  one-hot, single-cycle clear pulse to the delta registers.
- EVT_VALID  out  1  event available.
- EVT_READY  in  1  host accepts the event.
- EVT_ID  out  ID_W  index of the granted source; ID_W = max(1, $clog2(NUM_SOURCES)).
- EVT_VALUE  out  DATA_WIDTH  value snapshot taken at grant.
- IRQ  out  1  registered OR of (CHANGE_IN & ENABLE_MASK).
- TIMEOUT_FLAG  out  1  sticky watchdog flag. Present only with DELTA_SCHED_TIMEOUT_EN.

## Operation
- FSM states: IDLE, PRESENT, CLEAR, SETTLE.
- IDLE:
  - pending = CHANGE_IN & ENABLE_MASK.
  - If pending ≠ 0, the round-robin picker selects the first set bit at or above rr_ptr, wrapping around.
  - Register the selected index into EVT_ID and its VALUE_IN slice into EVT_VALUE, then go to PRESENT.
- PRESENT:
  - EVT_VALID = 1; EVT_ID and EVT_VALUE are held stable.
  - When EVT_VALID && EVT_READY: rr_ptr ← (EVT_ID+1) mod NUM_SOURCES, then go to CLEAR.
- CLEAR:
  - READ_EVENT_OUT[EVT_ID] = 1 for exactly this cycle; all other bits are 0.
  - Go to SETTLE.
- SETTLE:
  - One idle cycle so the cleared flag drops before re-arbitration.
  - Go to IDLE.
- Clearing ENABLE_MASK or CHANGE_IN after the grant does not cancel the event. It is still delivered and cleared.
- Sources whose mask bit is 0 are never granted and never cleared.
- NUM_SOURCES = 1: rr_ptr is constant 0.
- Reset values: state IDLE, rr_ptr 0, EVT_VALID 0, EVT_ID 0, EVT_VALUE 0, READ_EVENT_OUT 0, IRQ 0, TIMEOUT_FLAG 0.
- Reset asserted mid-event aborts immediately. No READ_EVENT_OUT pulse is issued, so the source flag stays set and is re-delivered after reset.

## Timing
- Pending visible in IDLE at cycle t: EVT_VALID = 1 at t+1.
- Handshake at cycle h: READ_EVENT_OUT pulse at h+1, SETTLE at h+2, IDLE at h+3, next EVT_VALID no earlier than h+4.
- Back-to-back throughput is one event per 4 cycles with EVT_READY held high.
- IRQ follows pending with 1-cycle latency and is independent of FSM state.
- EVT_VALID never drops without a handshake, except on timeout or reset.

## Configuration
- DELTA_SCHED_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) runs while in PRESENT and resets on entry to PRESENT.
  - When it reaches TIMEOUT_CYCLES with no handshake, the FSM goes to CLEAR. The event is dropped but still cleared, rr_ptr advances, and TIMEOUT_FLAG is set.
  - TIMEOUT_FLAG is sticky and is cleared only by reset.
- Not defined: no counter and no TIMEOUT_FLAG port. PRESENT waits indefinitely.

## Structure
- Package delta_sched_pkg holds:
  - state enum typedef (IDLE, PRESENT, CLEAR, SETTLE);
  - an id_width(n) function returning max(1, $clog2(n)).
- Sub-module rr_picker: combinational round-robin first-set-bit search. Inputs: request vector and pointer. Outputs: grant index and any-grant flag. Parameterised by NUM_SOURCES.

## Test plan
- Single source: CHANGE_IN = 0x04, VALUE_IN slice 2 = 0xDEADBEEF, EVT_READY = 1 → EVT_ID = 2, EVT_VALUE = 0xDEADBEEF one cycle after pending; READ_EVENT_OUT = 0x04 for one cycle, 2 cycles after grant.
- Fairness: CHANGE_IN = 0xFF held high, READY = 1 → EVT_ID sequence 0,1,…,7,0, spaced 4 cycles apart.
- Backpressure: READY = 0 for 20 cycles while VALUE_IN changes → EVT_VALID stays 1 and EVT_VALUE stays at the grant-time value; no clear until READY = 1.
- Mask: ENABLE_MASK = 0xFE with CHANGE_IN = 0x03 → only ID 1 is delivered; READ_EVENT_OUT[0] never pulses; IRQ = 1.
- Reset mid-PRESENT: RSTN low while EVT_VALID = 1 → all outputs 0 immediately; after release the same source is re-delivered.
- With DELTA_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES = 16, READY held at 0 → event dropped and cleared after 16 cycles; TIMEOUT_FLAG = 1 and stays set.
